// File: rtl/shift_r_share_ctrl_pkg.sv
// Shared types and the round-robin pick function used by the shifter-sharing
// controller.
package shift_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Upper bound on requesters the pick function can search.
  localparam int MAX_NREQ = 32;
  localparam int PICK_W   = $clog2(MAX_NREQ);

  // Returns the first set index of valid[nreq-1:0], searching upward from
  // ptr+1 and wrapping. The caller decides what to do when no bit is set.
  function automatic int rr_pick(input logic [MAX_NREQ-1:0] valid,
                                 input int                   ptr,
                                 input int                   nreq);
    int idx;
    rr_pick = ptr;
    // Walk from the farthest candidate down so the nearest valid one wins.
    for (int k = MAX_NREQ; k >= 1; k--) begin
      idx = ptr + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k <= nreq && valid[idx[PICK_W-1:0]]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/shift_r_nbit.sv
// Combinational logical right shift, zero-filled: y = a >> b.
module shift_r_nbit #(
  parameter int WIDTH       = 8,
  parameter int SHIFT_WIDTH = 3
) (
  input  logic [WIDTH-1:0]       a_i,
  input  logic [SHIFT_WIDTH-1:0] b_i,
  output logic [WIDTH-1:0]       y_o
);

  assign y_o = a_i >> b_i;

endmodule

// File: rtl/shift_r_share_ctrl.sv
// Round-robin arbiter and three-state controller that lets NREQ requesters
// share a single shift_r_nbit instance, returning ID-tagged results.
module shift_r_share_ctrl
  import shift_ctrl_pkg::*;
#(
  parameter  int WIDTH       = 8,
  parameter  int SHIFT_WIDTH = 3,
  parameter  int NREQ        = 4,
  localparam int IDW         = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_y,
  output logic [IDW-1:0]        rsp_id
);

  state_t                 state_q;
  logic [IDW-1:0]         ptr_q;
  logic [WIDTH-1:0]       a_q;
  logic [SHIFT_WIDTH-1:0] b_q;
  logic [IDW-1:0]         id_q;
  logic                   rsp_valid_q;
  logic [WIDTH-1:0]       rsp_y_q;
  logic [IDW-1:0]         rsp_id_q;

  logic [MAX_NREQ-1:0]    valid_ext;
  logic [IDW-1:0]         grant;
  logic                   req_fire;
  logic [WIDTH-1:0]       shift_y;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    valid_ext              = '0;
    valid_ext[NREQ-1:0]    = req_valid;
    grant                  = IDW'(rr_pick(valid_ext, int'(ptr_q), NREQ));
    req_fire               = (state_q == IDLE) && (|req_valid);
    req_ready              = '0;
    if (req_fire) req_ready[grant] = 1'b1;
  end

  shift_r_nbit #(
    .WIDTH       (WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_shift (
    .a_i (a_q),
    .b_i (b_q),
    .y_o (shift_y)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= IDW'(NREQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            a_q     <= req_a[grant*WIDTH +: WIDTH];
            b_q     <= req_b[grant*WIDTH +: SHIFT_WIDTH];
            id_q    <= grant;
            ptr_q   <= grant;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          rsp_y_q     <= shift_y;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          // Result fields hold until the consumer takes them.
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_id    = rsp_id_q;

endmodule
